mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory of the 16-bit multicycle CPU. It shares the memory between the CPU control path (fetch, load, store) and the program loader that fills memory from the external input port. It runs the request/grant/done handshake, drives the memory port, and raises a stall that freezes the control FSM while a CPU access is outstanding.

## Interface
Parameters:
- ADDR_W, 16, address width passed through to memory
- DATA_W, 16, data word width
- MEM_LAT, 1, synchronous memory read latency in cycles (>=1)

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- boot_hold  in  1  when 1, CPU requests are never granted
- cpu_req, cpu_we  in  1 each  CPU request, write enable
- cpu_addr, cpu_wdata  in  ADDR_W / DATA_W  CPU address, write data
- cpu_gnt, cpu_done, cpu_stall  out  1 each  grant, completion pulse, stall to control FSM
- cpu_rdata  out  DATA_W  CPU read data
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  as CPU  loader request side
- ldr_gnt, ldr_done  out  1 each  loader grant, completion pulse
- ldr_rdata  out  DATA_W  loader read data
- mem_en, mem_we  out  1 each  memory enable, write enable
- mem_addr, mem_wdata  out  ADDR_W / DATA_W  memory address, write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ACC, WAIT, DONE. Owner register is CPU or LDR.
- IDLE: evaluate requests. Eligible CPU = cpu_req & ~boot_hold. Eligible LDR = ldr_req.
  - One eligible: grant it.
  - Both eligible: grant the requester that is not last_owner (round-robin).
  - On grant, capture we, addr and wdata from the granted side, set owner and last_owner, go to ACC.
  - No eligible request: stay in IDLE.
- ACC (1 cycle): mem_en=1; mem_we=captured we; mem_addr and mem_wdata are the captured values. Load the down-counter with MEM_LAT. Go to WAIT.
- WAIT (MEM_LAT cycles): mem_en=0; mem_addr and mem_wdata hold their values.
  - Counter reaching zero ends WAIT. On that closing edge, if the access is a read, the owner's rdata register <= mem_rdata. Go to DONE.
- DONE (1 cycle): owner's done=1, then go to IDLE.
- Grant: x_gnt=1 in ACC and WAIT for the owner only.
- rdata registers update only on reads. A write leaves both rdata registers unchanged. The non-owner's rdata never changes.
- Requester rule: hold req, we, addr and wdata stable from assertion until done. Drop req in the done cycle or the cycle after.
  - A request still high in IDLE after its done is treated as a new access.
- Early deassert is a protocol violation. A granted access still completes and done still pulses.
- cpu_stall = cpu_req & ~cpu_done (combinational).
- Addresses pass through unchecked. Out-of-range handling belongs to the memory.

## Timing
- Reset values (async on reset_n=0): state IDLE; owner LDR; last_owner LDR, so the CPU wins the first tie; all gnt/done/mem_en/mem_we = 0; mem_addr, mem_wdata and both rdata = 0; counter 0.
- Reset mid-access aborts it: no done is ever issued for that access, and memory sees no further enable.
- Request seen in IDLE at cycle 0:
  - gnt and mem_en in cycle 1
  - WAIT in cycles 2..1+MEM_LAT
  - done and valid rdata in cycle 2+MEM_LAT
  - IDLE in cycle 3+MEM_LAT
- Throughput: one access per MEM_LAT+3 cycles. No back-to-back grant out of DONE.
- rdata stays valid from the done cycle until the next read by the same requester completes.
- boot_hold changes take effect at the next IDLE evaluation. An in-flight CPU access is never aborted.
- A request arriving while another access is in flight waits until IDLE. The waiting requester wins the next tie, because it is not last_owner.

## Test plan
- Reset: assert reset_n=0 during WAIT of a CPU read, release 3 cycles later -> all outputs 0, no cpu_done, next access served normally.
- CPU read (MEM_LAT=1), memory[0x0010]=0xBEEF, cpu_req at cycle 0 -> cpu_gnt=1 and mem_en=1 with mem_addr=0x0010 in cycle 1; cpu_done=1 and cpu_rdata=0xBEEF in cycle 3; cpu_stall high in cycles 0–2, low in cycle 3.
- Loader write 0x1234 to 0x0005, then CPU read of 0x0005 -> mem_we=1 only in the loader ACC cycle; cpu_rdata=0x1234; ldr_rdata unchanged at 0.
- Both requesting continuously after reset (each drops req in its done cycle, re-raises next cycle) -> grant order CPU, LDR, CPU, LDR; no overlapping gnt.
- boot_hold=1 with both requesting -> only loader accesses, cpu_stall stays 1. Drop boot_hold -> CPU granted at the next IDLE.
- MEM_LAT=3, CPU read of 0x00FF=0x00AA -> cpu_done in cycle 5, cpu_rdata=0x00AA. A following CPU write of 0x5555 leaves cpu_rdata=0x00AA.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/grant/done bundle between the CPU control path, the program loader,
// the arbiter and the single-ported unified memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              boot_hold;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_done, cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ldr_req, ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt, ldr_done;
  logic [DATA_W-1:0] ldr_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  boot_hold,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_stall, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_done, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output boot_hold,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_stall, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_done, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous memory between the CPU
// and the program loader; one access at a time, IDLE -> ACC -> WAIT -> DONE.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  mem_arbiter_if.slave bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

  // owner/last_owner encoding: 1 = CPU, 0 = loader
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic cpu_el, ldr_el, pick_cpu;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign cpu_el   = bus.cpu_req & ~bus.boot_hold;
  assign ldr_el   = bus.ldr_req;
  // On a tie the side that did not own the previous access wins
  assign pick_cpu = cpu_el & (~ldr_el | ~last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_el || ldr_el) begin
          owner_d = pick_cpu;
          last_d  = pick_cpu;
          we_d    = pick_cpu ? bus.cpu_we    : bus.ldr_we;
          addr_d  = pick_cpu ? bus.cpu_addr  : bus.ldr_addr;
          wdata_d = pick_cpu ? bus.cpu_wdata : bus.ldr_wdata;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        cnt_d   = CW'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Memory data is valid in the last WAIT cycle; capture on its closing edge
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_q) cpu_rdata_d = bus.mem_rdata;
            else         ldr_rdata_d = bus.mem_rdata;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = (state_q == S_ACC);
    bus.mem_we    = (state_q == S_ACC) & we_q;
    bus.cpu_gnt   = ((state_q == S_ACC) || (state_q == S_WAIT)) & owner_q;
    bus.ldr_gnt   = ((state_q == S_ACC) || (state_q == S_WAIT)) & ~owner_q;
    bus.cpu_done  = (state_q == S_DONE) & owner_q;
    bus.ldr_done  = (state_q == S_DONE) & ~owner_q;
    bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances,
// each backed by a small synchronous memory model.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .bus(b1.slave));
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (.clock(clock), .reset_n(reset_n), .bus(b3.slave));

  // Memory models; the preload port writes the same word into both
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a  = '0;
  logic [15:0] pl_d  = '0;
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] rd1, rd3a, rd3b, rd3c;

  always @(posedge clock) begin
    if (pl_en) mem1[pl_a] <= pl_d;
    else if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    if (b1.mem_en) rd1 <= mem1[b1.mem_addr[7:0]];
  end
  always @(posedge clock) begin
    if (pl_en) mem3[pl_a] <= pl_d;
    else if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
    if (b3.mem_en) rd3a <= mem3[b3.mem_addr[7:0]];
    rd3b <= rd3a;
    rd3c <= rd3b;
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = rd3c;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock); #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic clr_inputs();
    b1.boot_hold = 0; b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = '0; b1.ldr_wdata = '0;
    b3.boot_hold = 0; b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.ldr_req = 0; b3.ldr_we = 0; b3.ldr_addr = '0; b3.ldr_wdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clr_inputs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_a = a; pl_d = d; pl_en = 1;
    @(posedge clock); #1 pl_en = 0;
  endtask

  initial begin
    int ov, nst, gc, sl, ld, bad_rst;
    logic [3:0] seq;
    logic pc, pl, dc, dl;

    clr_inputs();
    preload(8'h10, 16'hBEEF);
    preload(8'hFF, 16'h00AA);

    // Reset state
    reset_n = 0;
    mid();
    chk("rst_gnt",   {b1.cpu_gnt, b1.ldr_gnt}, 0);
    chk("rst_done",  {b1.cpu_done, b1.ldr_done}, 0);
    chk("rst_mem",   {b1.mem_en, b1.mem_we}, 0);
    chk("rst_addr",  {b1.mem_addr, b1.mem_wdata}, 0);
    chk("rst_rdata", {b1.cpu_rdata, b1.ldr_rdata}, 0);
    do_reset();

    // CPU read 0x0010 with MEM_LAT=1
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0010;
    mid(); chk("rd_c0_stall", b1.cpu_stall, 1); chk("rd_c0_gnt", b1.cpu_gnt, 0);
    adv(); mid();
    chk("rd_c1_gnt", b1.cpu_gnt, 1); chk("rd_c1_en", b1.mem_en, 1);
    chk("rd_c1_addr", b1.mem_addr, 16'h0010); chk("rd_c1_stall", b1.cpu_stall, 1);
    adv(); mid();
    chk("rd_c2_en", b1.mem_en, 0); chk("rd_c2_gnt", b1.cpu_gnt, 1); chk("rd_c2_stall", b1.cpu_stall, 1);
    adv(); mid();
    chk("rd_c3_done", b1.cpu_done, 1); chk("rd_c3_rdata", b1.cpu_rdata, 16'hBEEF);
    chk("rd_c3_stall", b1.cpu_stall, 0); chk("rd_c3_gnt", b1.cpu_gnt, 0);
    adv(); b1.cpu_req = 0;
    mid(); chk("rd_c4_done", b1.cpu_done, 0); chk("rd_c4_hold", b1.cpu_rdata, 16'hBEEF);
    adv();

    // Loader write 0x1234 -> 0x0005, then CPU read back
    b1.ldr_req = 1; b1.ldr_we = 1; b1.ldr_addr = 16'h0005; b1.ldr_wdata = 16'h1234;
    adv(); mid();
    chk("lw_c1_gnt", {b1.ldr_gnt, b1.cpu_gnt}, 2'b10); chk("lw_c1_we", b1.mem_we, 1);
    chk("lw_c1_bus", {b1.mem_addr, b1.mem_wdata}, {16'h0005, 16'h1234});
    adv(); mid(); chk("lw_c2_we", b1.mem_we, 0);
    adv(); mid(); chk("lw_c3_done", b1.ldr_done, 1);
    adv();
    b1.ldr_req = 0; b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0005;
    adv(); mid(); chk("rb_c1_we", b1.mem_we, 0); chk("rb_c1_gnt", b1.cpu_gnt, 1);
    adv(); adv(); mid();
    chk("rb_c3_done", b1.cpu_done, 1); chk("rb_rdata", b1.cpu_rdata, 16'h1234);
    chk("rb_ldr_rdata", b1.ldr_rdata, 0);
    adv(); b1.cpu_req = 0;

    // Round robin with both requesting continuously
    do_reset();
    b1.cpu_req = 1; b1.cpu_addr = 16'h0010;
    b1.ldr_req = 1; b1.ldr_we = 1; b1.ldr_addr = 16'h0030; b1.ldr_wdata = 16'h7777;
    ov = 0; nst = 0; seq = '0; pc = 0; pl = 0;
    for (int i = 0; i < 16; i++) begin
      mid();
      if (b1.cpu_gnt && b1.ldr_gnt) ov++;
      if (b1.cpu_gnt && !pc) begin seq = {seq[2:0], 1'b1}; nst++; end
      if (b1.ldr_gnt && !pl) begin seq = {seq[2:0], 1'b0}; nst++; end
      pc = b1.cpu_gnt; pl = b1.ldr_gnt;
      dc = b1.cpu_done; dl = b1.ldr_done;
      if (dc) b1.cpu_req = 0;
      if (dl) b1.ldr_req = 0;
      adv();
      if (dc) b1.cpu_req = 1;
      if (dl) b1.ldr_req = 1;
    end
    chk("rr_starts", nst, 4);
    chk("rr_order", seq, 4'b1010);
    chk("rr_overlap", ov, 0);
    chk("rr_mem_wr", mem1[8'h30], 16'h7777);

    // boot_hold blocks the CPU; dropping it lets the CPU in at the next IDLE
    do_reset();
    b1.boot_hold = 1;
    b1.cpu_req = 1; b1.cpu_addr = 16'h0010;
    b1.ldr_req = 1; b1.ldr_we = 1; b1.ldr_addr = 16'h0031; b1.ldr_wdata = 16'h0001;
    gc = 0; sl = 0; ld = 0; dl = 0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) begin
        adv();
        if (dl) b1.ldr_req = 1;
      end
      mid();
      if (b1.cpu_gnt) gc++;
      if (!b1.cpu_stall) sl++;
      dl = b1.ldr_done;
      if (dl) ld++;
      if (dl) b1.ldr_req = 0;
    end
    chk("bh_cpu_gnt", gc, 0);
    chk("bh_stall_low", sl, 0);
    chk("bh_ldr_done", ld, 3);
    adv();
    b1.ldr_req = 1; b1.boot_hold = 0;
    mid(); chk("bh_c12_gnt", b1.cpu_gnt, 0);
    adv(); mid(); chk("bh_c13_gnt", {b1.cpu_gnt, b1.ldr_gnt}, 2'b10);
    adv(); adv(); mid();
    chk("bh_cpu_done", b1.cpu_done, 1); chk("bh_cpu_rdata", b1.cpu_rdata, 16'hBEEF);
    adv(); b1.cpu_req = 0; b1.ldr_req = 0;

    // MEM_LAT=3 read then write
    do_reset();
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 16'h00FF;
    adv(); mid(); chk("l3_c1_en", {b3.mem_en, b3.cpu_gnt}, 2'b11);
    adv(); adv(); adv(); mid();
    chk("l3_c4_done", b3.cpu_done, 0); chk("l3_c4_gnt", b3.cpu_gnt, 1);
    adv(); mid();
    chk("l3_c5_done", b3.cpu_done, 1); chk("l3_rdata", b3.cpu_rdata, 16'h00AA);
    adv();
    b3.cpu_we = 1; b3.cpu_addr = 16'h0020; b3.cpu_wdata = 16'h5555;
    repeat (5) adv();
    mid();
    chk("l3w_done", b3.cpu_done, 1); chk("l3w_rdata_kept", b3.cpu_rdata, 16'h00AA);
    chk("l3w_mem", mem3[8'h20], 16'h5555);
    adv(); b3.cpu_req = 0;

    // Reset during WAIT of a CPU read aborts it
    do_reset();
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h0010;
    adv(); adv();
    reset_n = 0; b1.cpu_req = 0;
    mid();
    chk("ra_outs", {b1.cpu_gnt, b1.ldr_gnt, b1.cpu_done, b1.mem_en, b1.mem_we}, 0);
    chk("ra_rdata", b1.cpu_rdata, 0);
    bad_rst = 0;
    for (int i = 0; i < 3; i++) begin
      adv(); mid();
      if (b1.cpu_done || b1.mem_en || b1.cpu_gnt) bad_rst++;
    end
    adv(); reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (b1.cpu_done || b1.mem_en || b1.cpu_gnt) bad_rst++;
      adv();
    end
    chk("ra_quiet", bad_rst, 0);
    b1.cpu_req = 1; b1.cpu_addr = 16'h0010;
    adv(); adv(); adv(); mid();
    chk("ra_next_done", b1.cpu_done, 1); chk("ra_next_rdata", b1.cpu_rdata, 16'hBEEF);
    adv(); b1.cpu_req = 0;
    adv();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
